duc_tx: RTL
===========

DUC_TX -- requirements
Module: duc_tx

Interface
REQ-001 The block SHALL have a parameter INTERP, default 4, giving the number of DAC samples each I/Q input sample is held for; legal range is 2..64.
REQ-002 The block SHALL have an input clk, 1 bit: the single clock for all logic.
REQ-003 The block SHALL have an input reset, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have an input dds_tdata, 16 bits: [15:8] is signed 8-bit sin and [7:0] is signed 8-bit cos.
REQ-005 The block SHALL have an input dds_val, 1 bit: DDS sample valid, which also acts as the pipeline clock-enable (CE).
REQ-006 The block SHALL have an input i_in, signed 16 bits: baseband in-phase sample.
REQ-007 The block SHALL have an input q_in, signed 16 bits: baseband quadrature sample.
REQ-008 The block SHALL have an input iq_val, 1 bit: I/Q sample valid.
REQ-009 The block SHALL have an output iq_rdy, 1 bit: the block accepts I/Q this cycle.
REQ-010 The block SHALL have an output dac_out, signed 16 bits: the real upconverted sample.
REQ-011 The block SHALL have an output dac_val, 1 bit: dac_out valid.
REQ-012 The block SHALL have an output underrun, 1 bit: sticky flag set when the hold interval expires with no new I/Q sample.
REQ-013 The block SHALL have an output sat, 1 bit: single-cycle pulse when dac_out was clipped; it is tied 0 when saturation is compiled out.

Function
REQ-014 The block SHALL hold I/Q in a register pair (H_I, H_Q), together with a loaded flag and a hold counter cnt in 0..INTERP-1.
REQ-015 The block SHALL drive iq_rdy = dds_val AND (NOT loaded OR cnt == INTERP-1); iq_rdy is combinational and does not depend on iq_val.
REQ-016 On iq_val AND iq_rdy, the block SHALL load H_I/H_Q, set loaded to 1 and set cnt to 0.
REQ-017 Otherwise, on a CE cycle with loaded=1 and cnt<INTERP-1, the block SHALL increment cnt.
REQ-018 On a CE cycle with loaded=1, cnt==INTERP-1 and no accepted sample, the block SHALL clear loaded, set cnt to 0 and set underrun.
REQ-019 The mixer operands SHALL be H_I/H_Q when loaded=1, and 0/0 when loaded=0.
REQ-020 The block SHALL compute mix = I*cos - Q*sin, using full-precision 24-bit products and a 25-bit signed difference.
REQ-021 The output scaling SHALL be dac_out = mix[22:7], with truncation and no rounding.
REQ-022 The pipeline SHALL be 4 registered stages (operand, multiply, subtract, scale), all enabled by CE.
REQ-023 The operands present on CE cycle n SHALL appear on dac_out after exactly 4 CE edges.
REQ-024 The dds_val=0 cycles SHALL freeze all state (pipeline, cnt, loaded) and force dac_val=0, with no data lost; they are excluded from the latency count.
REQ-025 The dac_val output SHALL rise on the 4th CE edge after reset and thereafter equal dds_val delayed by 1 cycle (it tracks CE).
REQ-026 An iq_val asserted while iq_rdy=0 SHALL be ignored, and the source holds the data.

Reset
REQ-027 The block SHALL set the pipeline registers, H_I, H_Q, cnt, loaded, underrun and sat to 0, and set dac_out to 0x0000 and dac_val to 0, on reset.
REQ-028 A reset asserted mid-run SHALL discard all in-flight samples, restart the 4-CE fill and clear underrun.
REQ-029 While reset is high, iq_rdy SHALL be 0.

Configuration
REQ-030 The macro DUC_TX_SAT_EN, when defined, SHALL cause the block to saturate: if mix[24:22] are not all equal, dac_out = 0x7FFF (positive) or 0x8000 (negative), and sat pulses 1 on that output cycle.
REQ-031 When DUC_TX_SAT_EN is undefined, dac_out SHALL be the plain slice mix[22:7] (wrap) and sat SHALL be held 0.

Verification
REQ-032 Scenario (I path): cos=127, sin=0, I=0x4000, Q=0, dds_val=1 -> dac_out=0x3F80 four CE cycles after the operands are applied.
REQ-033 Scenario (Q path): cos=0, sin=127, I=0, Q=0x4000 -> dac_out=0xC080 (-16256).
REQ-034 Scenario (overflow): I=0x7FFF, Q=0x8000, cos=127, sin=127 -> with DUC_TX_SAT_EN, dac_out=0x7FFF and sat=1; without it, dac_out=0xFDFE and sat=0.
REQ-035 Scenario (handshake): INTERP=4, iq_val held 1 -> iq_rdy high 1 in every 4 CE cycles, and each sample is held for 4 dac_val cycles.
REQ-036 Scenario (underrun): INTERP=4, a single sample 0x4000/0 then iq_val=0 -> 4 outputs of 0x3F80, then 0x0000 outputs, and underrun=1 until reset.
REQ-037 Scenario (stall and reset): dds_val low for 3 cycles mid-stream -> dac_val low for those 3 cycles and no samples lost or duplicated; reset mid-stream -> dac_val=0, and dac_val returns after 4 CE edges.

Source files
------------

// File: rtl/duc_tx.sv
// duc_tx: I/Q hold-interpolator and 4-stage complex-to-real upconverting mixer.
// Optional output saturation is enabled by defining DUC_TX_SAT_EN.
module duc_tx #(
    parameter int INTERP = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic        [15:0] dds_tdata,
    input  logic               dds_val,
    input  logic signed [15:0] i_in,
    input  logic signed [15:0] q_in,
    input  logic               iq_val,
    output logic               iq_rdy,
    output logic signed [15:0] dac_out,
    output logic               dac_val,
    output logic               underrun,
    output logic               sat
);
    localparam int CW = INTERP > 1 ? $clog2(INTERP) : 1;
    localparam logic [CW-1:0] LAST = CW'(INTERP - 1);
`ifdef DUC_TX_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic signed [15:0] h_i, h_q, a_i, a_q;
    logic signed [7:0]  a_c, a_s;
    logic signed [23:0] p_c, p_s;
    logic signed [24:0] mix;
    logic signed [15:0] scaled;
    logic [CW-1:0]      cnt;
    logic [2:0]         fill;
    logic               loaded, accept, ovf;

    assign iq_rdy = dds_val && !reset && (!loaded || cnt == LAST);
    assign accept = iq_val && iq_rdy;
    // Anything outside the 23-bit signed range cannot be represented by mix[22:7].
    assign ovf    = (mix[24:22] != 3'b000) && (mix[24:22] != 3'b111);
    assign scaled = (SAT_EN && ovf) ? (mix[24] ? 16'sh8000 : 16'sh7FFF) : mix[22:7];

    always_ff @(posedge clk) begin
        if (reset) begin
            h_i      <= '0;
            h_q      <= '0;
            loaded   <= 1'b0;
            cnt      <= '0;
            underrun <= 1'b0;
        end else if (accept) begin
            h_i      <= i_in;
            h_q      <= q_in;
            loaded   <= 1'b1;
            cnt      <= '0;
        end else if (dds_val && loaded) begin
            if (cnt == LAST) begin
                loaded   <= 1'b0;
                cnt      <= '0;
                underrun <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_i     <= '0;
            a_q     <= '0;
            a_c     <= '0;
            a_s     <= '0;
            p_c     <= '0;
            p_s     <= '0;
            mix     <= '0;
            dac_out <= '0;
            fill    <= '0;
        end else if (dds_val) begin
            a_i     <= loaded ? h_i : 16'sd0;
            a_q     <= loaded ? h_q : 16'sd0;
            a_c     <= dds_tdata[7:0];
            a_s     <= dds_tdata[15:8];
            p_c     <= 24'(a_i) * 24'(a_c);
            p_s     <= 24'(a_q) * 24'(a_s);
            mix     <= {p_c[23], p_c} - {p_s[23], p_s};
            dac_out <= scaled;
            fill    <= fill + {2'b00, fill != 3'd4};
        end
    end

    // Valid and the clip flag follow CE by one cycle once the pipeline has filled.
    always_ff @(posedge clk) begin
        if (reset) begin
            dac_val <= 1'b0;
            sat     <= 1'b0;
        end else begin
            dac_val <= dds_val && (fill >= 3'd3);
            sat     <= dds_val && SAT_EN && ovf;
        end
    end
endmodule
